fp_add_sequencer: RTL and testbench

//  Multi-cycle controller for single-precision (IEEE-754 binary32) add/sub in the FP unit.

---
 rtl/fp_add_sequencer_pkg.sv | 43 ++++
 rtl/fp_add_sequencer_if.sv | 24 ++
 rtl/fp_add_sequencer_align_shifter.sv | 24 ++
 rtl/fp_add_sequencer.sv | 232 +++++++++++++++++++++++
 tb/tb_fp_add_sequencer.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/fp_add_sequencer_pkg.sv
// Shared constants, state encoding and operand helpers for the multi-cycle
// binary32 add/sub sequencer.
package fp_add_sequencer_pkg;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int GRS_W = 3;
  localparam int SIG_W = MAN_W + 1 + GRS_W;  // hidden + stored + guard/round/sticky
  localparam int SUM_W = SIG_W + 1;          // plus carry-out

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  localparam int FLAG_INVALID   = 3;
  localparam int FLAG_OVERFLOW  = 2;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_INEXACT   = 0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_UNPACK = 3'd1,
    ST_ALIGN  = 3'd2,
    ST_ADD    = 3'd3,
    ST_NORM   = 3'd4,
    ST_ROUND  = 3'd5,
    ST_DONE   = 3'd6
  } state_t;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W:0]   man;   // includes hidden bit
  } operand_t;

  // Denormals (exp==0) are flushed to a signed zero; flip applies the subtract.
  function automatic operand_t split(input logic [31:0] v, input logic flip);
    operand_t o;
    o.sign = v[31] ^ flip;
    o.exp  = v[30:23];
    o.man  = (v[30:23] == '0) ? '0 : {1'b1, v[22:0]};
    return o;
  endfunction

endpackage

// File: rtl/fp_add_sequencer_if.sv
// Operand/result handshake bundle for the binary32 add/sub sequencer.
// valid/ready: a transfer occurs on a rising edge where valid and ready are both
// high; the producer holds valid and its payload stable until that edge.
interface fp_add_sequencer_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_sub;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [3:0]  out_flags;

  modport master (
    output in_valid, in_a, in_b, in_sub, out_ready,
    input  in_ready, out_valid, out_result, out_flags
  );

  modport slave (
    input  in_valid, in_a, in_b, in_sub, out_ready,
    output in_ready, out_valid, out_result, out_flags
  );
endinterface

// File: rtl/fp_add_sequencer_align_shifter.sv
// fp_align_shifter: logical right shift of the 27-bit significand by the
// exponent difference, reporting the OR of every bit shifted out as sticky.
module fp_align_shifter
  import fp_add_sequencer_pkg::*;
(
  input  logic [SIG_W-1:0] data,
  input  logic [EXP_W-1:0] amount,
  output logic [SIG_W-1:0] shifted,
  output logic             sticky
);

  logic [SIG_W-1:0] lost_mask;

  always_comb begin
    shifted   = '0;
    lost_mask = '1;
    if (amount < EXP_W'(SIG_W)) begin
      shifted   = data >> amount;
      lost_mask = (SIG_W'(1) << amount) - SIG_W'(1);
    end
    sticky = |(data & lost_mask);
  end

endmodule

// File: rtl/fp_add_sequencer.sv
// Multi-cycle binary32 add/sub: unpack, align, add, normalise (1 bit/cycle) and
// round-to-nearest-even over one shared datapath, one operation in flight.
module fp_add_sequencer
  import fp_add_sequencer_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  fp_add_sequencer_if.slave   bus,
  output logic                busy,
  output state_t              dbg_state
);

  state_t state, state_nxt;

  logic [31:0]        a_q, b_q;
  logic               sub_q;
  operand_t           op_a, op_b;
  logic               special_q;
  logic [31:0]        special_res_q;
  logic [3:0]         special_flags_q;
  logic               sign_q;
  logic signed [9:0]  exp_q;
  logic [SIG_W-1:0]   big_q, small_q;
  logic               eff_sub_q;
  logic [SUM_W-1:0]   sum_q;
  logic [31:0]        result_q;
  logic [3:0]         flags_q;

  // ---------------- special-operand decode (UNPACK) ----------------
  logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, b_sign;
  logic        sp_hit;
  logic [31:0] sp_res;
  logic [3:0]  sp_flags;

  always_comb begin
    a_nan    = (&a_q[30:23]) && (|a_q[22:0]);
    b_nan    = (&b_q[30:23]) && (|b_q[22:0]);
    a_inf    = (&a_q[30:23]) && !(|a_q[22:0]);
    b_inf    = (&b_q[30:23]) && !(|b_q[22:0]);
    a_zero   = (a_q[30:23] == '0);
    b_zero   = (b_q[30:23] == '0);
    b_sign   = b_q[31] ^ sub_q;
    sp_hit   = 1'b1;
    sp_res   = QNAN;
    sp_flags = '0;
    if (a_nan || b_nan) begin
      // Only a signalling NaN (quiet bit clear) raises invalid.
      sp_flags[FLAG_INVALID] = (a_nan && !a_q[22]) || (b_nan && !b_q[22]);
    end else if (a_inf && b_inf) begin
      if (a_q[31] != b_sign) sp_flags[FLAG_INVALID] = 1'b1;
      else                   sp_res = {a_q[31], 8'hFF, 23'd0};
    end else if (a_inf) begin
      sp_res = {a_q[31], 8'hFF, 23'd0};
    end else if (b_inf) begin
      sp_res = {b_sign, 8'hFF, 23'd0};
    end else if (a_zero && b_zero) begin
      sp_res = {a_q[31] & b_sign, 31'd0};
    end else begin
      sp_hit = 1'b0;
    end
  end

  // ---------------- operand selection and alignment (ALIGN) ----------------
  logic             swap;
  operand_t         op_big, op_small;
  logic [EXP_W-1:0] shift_amt;
  logic [SIG_W-1:0] small_shifted;
  logic             small_sticky;

  always_comb begin
    swap      = {op_b.exp, op_b.man} > {op_a.exp, op_a.man};
    op_big    = swap ? op_b : op_a;
    op_small  = swap ? op_a : op_b;
    shift_amt = op_big.exp - op_small.exp;
  end

  fp_align_shifter u_align (
    .data    ({op_small.man, {GRS_W{1'b0}}}),
    .amount  (shift_amt),
    .shifted (small_shifted),
    .sticky  (small_sticky)
  );

  // ---------------- normaliser step (NORM) ----------------
  logic [SUM_W-1:0]  norm_sum;
  logic signed [9:0] norm_exp;
  logic              norm_done;

  always_comb begin
    norm_sum  = sum_q;
    norm_exp  = exp_q;
    norm_done = 1'b1;
    if (sum_q[SUM_W-1]) begin
      norm_sum = {1'b0, sum_q[SUM_W-1:2], sum_q[1] | sum_q[0]};
      norm_exp = exp_q + 10'sd1;
    end else if ((sum_q != '0) && !sum_q[SUM_W-2] && (exp_q != 10'sd1)) begin
      // Exit decided on the post-shift value so k shifts cost exactly k cycles.
      norm_sum  = {sum_q[SUM_W-2:0], 1'b0};
      norm_exp  = exp_q - 10'sd1;
      norm_done = sum_q[SUM_W-3] || (exp_q == 10'sd2);
    end
  end

  // ---------------- round to nearest even (ROUND) ----------------
  logic [MAN_W:0]    rnd_man;
  logic              rnd_g, rnd_r, rnd_s, round_up, inexact;
  logic [MAN_W+1:0]  man_r;
  logic signed [9:0] exp_fin;
  logic [31:0]       rnd_res;
  logic [3:0]        rnd_flags;

  always_comb begin
    rnd_man   = sum_q[SIG_W-1:GRS_W];
    rnd_g     = sum_q[2];
    rnd_r     = sum_q[1];
    rnd_s     = sum_q[0];
    inexact   = rnd_g | rnd_r | rnd_s;
    round_up  = rnd_g & (rnd_r | rnd_s | rnd_man[0]);
    man_r     = {1'b0, rnd_man} + (MAN_W+2)'(round_up);
    exp_fin   = exp_q + $signed({9'd0, man_r[MAN_W+1]});
    rnd_res   = '0;
    rnd_flags = '0;
    if (sum_q == '0) begin
      rnd_res = '0;
    end else if (exp_fin >= 10'sd255) begin
      rnd_res                  = {sign_q, 8'hFF, 23'd0};
      rnd_flags[FLAG_OVERFLOW] = 1'b1;
      rnd_flags[FLAG_INEXACT]  = 1'b1;
    end else if (!man_r[MAN_W+1] && !man_r[MAN_W]) begin
      rnd_res                   = {sign_q, 31'd0};
      rnd_flags[FLAG_UNDERFLOW] = 1'b1;
      rnd_flags[FLAG_INEXACT]   = 1'b1;
    end else begin
      rnd_res = {sign_q, exp_fin[7:0],
                 man_r[MAN_W+1] ? man_r[MAN_W:1] : man_r[MAN_W-1:0]};
      rnd_flags[FLAG_INEXACT] = inexact;
    end
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (bus.in_valid) state_nxt = ST_UNPACK;
      ST_UNPACK: state_nxt = ST_ALIGN;
      ST_ALIGN:  state_nxt = special_q ? ST_DONE : ST_ADD;
      ST_ADD:    state_nxt = ST_NORM;
      ST_NORM:   if (norm_done) state_nxt = ST_ROUND;
      ST_ROUND:  state_nxt = ST_DONE;
      ST_DONE:   if (bus.out_ready) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q             <= '0;
      b_q             <= '0;
      sub_q           <= 1'b0;
      op_a            <= '0;
      op_b            <= '0;
      special_q       <= 1'b0;
      special_res_q   <= '0;
      special_flags_q <= '0;
      sign_q          <= 1'b0;
      exp_q           <= '0;
      big_q           <= '0;
      small_q         <= '0;
      eff_sub_q       <= 1'b0;
      sum_q           <= '0;
    end else begin
      case (state)
        ST_IDLE: if (bus.in_valid) begin
          a_q   <= bus.in_a;
          b_q   <= bus.in_b;
          sub_q <= bus.in_sub;
        end
        ST_UNPACK: begin
          op_a            <= split(a_q, 1'b0);
          op_b            <= split(b_q, sub_q);
          special_q       <= sp_hit;
          special_res_q   <= sp_res;
          special_flags_q <= sp_flags;
        end
        ST_ALIGN: begin
          sign_q    <= op_big.sign;
          exp_q     <= $signed({2'b00, op_big.exp});
          big_q     <= {op_big.man, {GRS_W{1'b0}}};
          small_q   <= {small_shifted[SIG_W-1:1], small_shifted[0] | small_sticky};
          eff_sub_q <= op_a.sign ^ op_b.sign;
        end
        ST_ADD: begin
          sum_q <= eff_sub_q ? ({1'b0, big_q} - {1'b0, small_q})
                             : ({1'b0, big_q} + {1'b0, small_q});
        end
        ST_NORM: begin
          sum_q <= norm_sum;
          exp_q <= norm_exp;
        end
        default: ;
      endcase
    end
  end

  // Result registers only change on the way into DONE, so they hold while waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      flags_q  <= '0;
    end else if (state == ST_ALIGN && special_q) begin
      result_q <= special_res_q;
      flags_q  <= special_flags_q;
    end else if (state == ST_ROUND) begin
      result_q <= rnd_res;
      flags_q  <= rnd_flags;
    end
  end

  assign bus.in_ready   = (state == ST_IDLE);
  assign bus.out_valid  = (state == ST_DONE);
  assign bus.out_result = result_q;
  assign bus.out_flags  = flags_q;
  assign busy           = (state != ST_IDLE);
  assign dbg_state      = state;

endmodule

// File: tb/tb_fp_add_sequencer.sv
// Directed bench for fp_add_sequencer: drivers push expected {flags,result}
// into a queue, a negedge monitor pops and compares on each output handshake.
module tb_fp_add_sequencer;
  import fp_add_sequencer_pkg::*;

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  logic   busy;
  state_t dbg_state;

  fp_add_sequencer_if bus ();

  fp_add_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  logic [35:0] exp_q[$];
  logic [35:0] mon_exp;
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [35:0] got, input logic [35:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, want);
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL spurious_output: got %h/%h with nothing expected",
                 bus.out_flags, bus.out_result);
      end else begin
        mon_exp = exp_q.pop_front();
        check("result", {bus.out_flags, bus.out_result}, mon_exp);
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sub);
    int waited = 0;
    @(negedge clk);
    while (!bus.in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 200) check("in_ready_timeout", 36'(waited), 36'd0);
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_sub   = sub;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  // lat = edges from the accept edge until out_valid is first seen high.
  task automatic send(input string name, input logic [31:0] a, input logic [31:0] b,
                      input logic sub, input logic [31:0] res, input logic [3:0] flags,
                      input int lat);
    int cyc = 0;
    exp_q.push_back({flags, res});
    issue(a, b, sub);
    while (!bus.out_valid && cyc < 100) begin
      @(posedge clk);
      cyc++;
      #1;
    end
    check({name, "_latency"}, 36'(cyc), 36'(lat));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_sub    = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    check("rst_in_ready",  36'(bus.in_ready),  36'd1);
    check("rst_out_valid", 36'(bus.out_valid), 36'd0);
    check("rst_busy",      36'(busy),          36'd0);
    check("rst_result",    36'(bus.out_result), 36'd0);
    check("rst_flags",     36'(bus.out_flags), 36'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Normal path: 1 NORM cycle unless cancellation needs k left shifts.
    send("one_plus_one",   32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000, 5);
    send("tie_to_even",    32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001, 5);
    send("round_up",       32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001, 4'b0001, 5);
    send("one_minus_one",  32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000, 5);
    // Difference 2^-24 sits at bit 2; 24 left shifts bring it to bit 26.
    send("deep_cancel",    32'h3F800000, 32'h3F7FFFFF, 1'b1, 32'h33800000, 4'b0000, 28);
    send("one_plus_neg2",  32'h3F800000, 32'hC0000000, 1'b0, 32'hBF800000, 4'b0000, 5);
    send("overflow",       32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101, 5);
    send("underflow",      32'h00C00000, 32'h00800000, 1'b1, 32'h00000000, 4'b0011, 5);
    // Specials skip the datapath.
    send("inf_minus_inf",  32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'b1000, 2);
    send("qnan_in",        32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b0000, 2);
    send("snan_in",        32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b1000, 2);
    send("inf_plus_one",   32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 4'b0000, 2);
    send("negz_minus_z",   32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 4'b0000, 2);
    send("denorm_flush",   32'h00400000, 32'h00000000, 1'b0, 32'h00000000, 4'b0000, 2);

    // Output held under back-pressure; in_valid while busy is ignored.
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    send("held",           32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000, 5);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        bus.in_a     = 32'h40400000;
        bus.in_b     = 32'h40400000;
        bus.in_valid = 1'b1;
      end
      @(negedge clk);
      check("hold_valid",  36'(bus.out_valid), 36'd1);
      check("hold_data",   {bus.out_flags, bus.out_result}, {4'b0000, 32'h40000000});
      if (i == 3) check("busy_in_ready", 36'(bus.in_ready), 36'd0);
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("release_in_ready",  36'(bus.in_ready),  36'd1);
    check("release_out_valid", 36'(bus.out_valid), 36'd0);
    repeat (8) @(negedge clk);
    check("ignored_not_run", 36'(busy), 36'd0);

    // Async reset in the middle of normalisation aborts the operation.
    issue(32'h3F800000, 32'h3F7FFFFF, 1'b1);
    repeat (10) @(posedge clk);
    #1 check("in_norm", 36'(dbg_state), 36'(ST_NORM));
    #2 rst_n = 1'b0;
    #1;
    check("abort_out_valid", 36'(bus.out_valid), 36'd0);
    check("abort_in_ready",  36'(bus.in_ready),  36'd1);
    check("abort_busy",      36'(busy),          36'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send("after_reset",    32'h40000000, 32'h40000000, 1'b0, 32'h40800000, 4'b0000, 5);

    repeat (5) @(negedge clk);
    check("queue_drained", 36'(exp_q.size()), 36'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
